// File: rtl/game_state_ctl_pkg.sv
// Shared game-screen types and the pixel hit-box helper.
package game_state_ctl_pkg;

  typedef enum logic [1:0] {
    START   = 2'd0,
    LEVEL_1 = 2'd1,
    FINISH  = 2'd2
  } g_state;

  // Inclusive left/top edge, exclusive right/bottom edge; sums are 13 bits so they never wrap.
  function automatic logic in_box(
    input logic [11:0] x,
    input logic [11:0] y,
    input logic [12:0] bx,
    input logic [12:0] by,
    input logic [12:0] bw,
    input logic [12:0] bh
  );
    logic [12:0] xw;
    logic [12:0] yw;
    xw = {1'b0, x};
    yw = {1'b0, y};
    return (xw >= bx) && (xw < bx + bw) && (yw >= by) && (yw < by + bh);
  endfunction

endpackage

// File: rtl/game_state_ctl_if.sv
// Frame/pointer/player inputs and the screen-select outputs of the game FSM.
interface game_state_ctl_if;

  logic                        vblnk;
  logic                        mouse_left;
  logic [11:0]                 xpos_mouse;
  logic [11:0]                 ypos_mouse;
  logic [11:0]                 xpos_player;
  logic [11:0]                 ypos_player;
  logic                        button_pressed;
  game_state_ctl_pkg::g_state  game_state;
  logic                        state_change;

  modport master (
    output vblnk, mouse_left, xpos_mouse, ypos_mouse,
           xpos_player, ypos_player, button_pressed,
    input  game_state, state_change
  );

  modport slave (
    input  vblnk, mouse_left, xpos_mouse, ypos_mouse,
           xpos_player, ypos_player, button_pressed,
    output game_state, state_change
  );

endinterface

// File: rtl/game_state_ctl_rise_edge.sv
// Single-register rising-edge detector; pulse is high in the first cycle d is seen high.
module rise_edge (
  input  logic clk_40,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge clk_40 or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/game_state_ctl.sv
// Top-level game FSM: raises screen-change requests and commits them only on a vblnk rising edge.
module game_state_ctl
  import game_state_ctl_pkg::*;
#(
  parameter int unsigned START_BTN_X   = 350,
  parameter int unsigned START_BTN_Y   = 280,
  parameter int unsigned START_BTN_W   = 100,
  parameter int unsigned START_BTN_H   = 40,
  parameter int unsigned EXIT_X        = 740,
  parameter int unsigned EXIT_Y        = 500,
  parameter int unsigned EXIT_W        = 60,
  parameter int unsigned EXIT_H        = 80,
  parameter int unsigned EXIT_DWELL    = 30,
  parameter int unsigned FINISH_FRAMES = 300
) (
  input  logic               clk_40,
  input  logic               rst,
  game_state_ctl_if.slave    gs
);

  localparam int unsigned DW = $clog2(EXIT_DWELL + 1);
  localparam int unsigned FW = $clog2(FINISH_FRAMES);
  localparam logic [DW-1:0] DWELL_MAX = DW'(EXIT_DWELL);
  localparam logic [FW-1:0] FIN_LAST  = FW'(FINISH_FRAMES - 1);

  logic          click;
  logic          frame;
  logic          in_start;
  logic          in_exit;
  logic          state_legal;

  g_state        state_q,   state_d;
  g_state        target_q,  target_d;
  logic          change_q,  change_d;
  logic          pending_q, pending_d;
  logic [DW-1:0] dwell_q,   dwell_d;
  logic [FW-1:0] fin_q,     fin_d;
  logic [DW-1:0] dwell_inc;
  logic [FW-1:0] fin_inc;

  rise_edge u_click_edge (
    .clk_40 (clk_40),
    .rst    (rst),
    .d      (gs.mouse_left),
    .pulse  (click)
  );

  rise_edge u_frame_edge (
    .clk_40 (clk_40),
    .rst    (rst),
    .d      (gs.vblnk),
    .pulse  (frame)
  );

  assign in_start = in_box(gs.xpos_mouse, gs.ypos_mouse,
                           13'(START_BTN_X), 13'(START_BTN_Y),
                           13'(START_BTN_W), 13'(START_BTN_H));
  assign in_exit  = in_box(gs.xpos_player, gs.ypos_player,
                           13'(EXIT_X), 13'(EXIT_Y),
                           13'(EXIT_W), 13'(EXIT_H));

  assign state_legal = (state_q == START) || (state_q == LEVEL_1) || (state_q == FINISH);
  assign dwell_inc   = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + 1'b1;
  assign fin_inc     = fin_q + 1'b1;

  always_ff @(posedge clk_40 or posedge rst) begin
    if (rst) begin
      state_q   <= START;
      target_q  <= START;
      change_q  <= 1'b0;
      pending_q <= 1'b0;
      dwell_q   <= '0;
      fin_q     <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      change_q  <= change_d;
      pending_q <= pending_d;
      dwell_q   <= dwell_d;
      fin_q     <= fin_d;
    end
  end

  // Commit (registered pending) takes priority; request logic only runs while nothing is pending,
  // so a request raised on a frame cycle waits for the following frame.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    change_d  = 1'b0;
    pending_d = pending_q;
    dwell_d   = dwell_q;
    fin_d     = fin_q;

    if (frame && !state_legal) begin
      state_d   = START;
      change_d  = 1'b1;
      pending_d = 1'b0;
      dwell_d   = '0;
      fin_d     = '0;
    end else if (frame && pending_q) begin
      state_d   = target_q;
      change_d  = 1'b1;
      pending_d = 1'b0;
      dwell_d   = '0;
      fin_d     = '0;
    end else if (!pending_q) begin
      case (state_q)
        START: begin
          if (click && in_start) begin
            pending_d = 1'b1;
            target_d  = LEVEL_1;
          end
        end
        LEVEL_1: begin
          if (frame) begin
            if (in_exit && gs.button_pressed) begin
              dwell_d = dwell_inc;
              if (dwell_inc == DWELL_MAX) begin
                pending_d = 1'b1;
                target_d  = FINISH;
              end
            end else begin
              dwell_d = '0;
            end
          end
        end
        FINISH: begin
          if (frame) fin_d = fin_inc;
          if ((frame && fin_inc == FIN_LAST) || click) begin
            pending_d = 1'b1;
            target_d  = START;
          end
        end
        default: ;
      endcase
    end
  end

  assign gs.game_state   = state_q;
  assign gs.state_change = change_q;

endmodule

// File: tb/tb_game_state_ctl.sv
// Self-checking bench for game_state_ctl: hit-box vector table, directed frame-timing sequences,
// and a randomized run against a frame-rule reference model.
`timescale 1ns/1ps
module tb_game_state_ctl;
  import game_state_ctl_pkg::*;

  logic clk_40 = 1'b0;
  logic rst;
  always #5 clk_40 = ~clk_40;

  game_state_ctl_if bus();

  game_state_ctl #(
    .START_BTN_X(350), .START_BTN_Y(280), .START_BTN_W(100), .START_BTN_H(40),
    .EXIT_X(740), .EXIT_Y(500), .EXIT_W(60), .EXIT_H(80),
    .EXIT_DWELL(30), .FINISH_FRAMES(300)
  ) dut (
    .clk_40 (clk_40),
    .rst    (rst),
    .gs     (bus)
  );

  int n_pass    = 0;
  int n_total   = 0;
  int n_changes = 0;
  bit model_chk = 1'b0;

  // Reference model state, expressed in game terms
  g_state m_state, m_tgt;
  bit     m_pend, m_change, m_vb_q, m_ml_q;
  int     m_dwell, m_fin;

  always @(negedge clk_40) if (bus.state_change === 1'b1) n_changes++;

  function automatic bit hit(input int x, input int y, input int bx, input int by,
                             input int bw, input int bh);
    return (x >= bx) && (x < bx + bw) && (y >= by) && (y < by + bh);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    m_state = START; m_tgt = START; m_pend = 0; m_change = 0;
    m_vb_q = 0; m_ml_q = 0; m_dwell = 0; m_fin = 0;
  endtask

  task automatic model_step();
    bit clk_ev, frm;
    clk_ev = bus.mouse_left && !m_ml_q;
    frm    = bus.vblnk && !m_vb_q;
    m_change = 0;
    if (frm && m_pend) begin
      m_state = m_tgt; m_change = 1; m_pend = 0; m_dwell = 0; m_fin = 0;
    end else if (!m_pend) begin
      if (m_state == START) begin
        if (clk_ev && hit(int'(bus.xpos_mouse), int'(bus.ypos_mouse), 350, 280, 100, 40)) begin
          m_pend = 1; m_tgt = LEVEL_1;
        end
      end else if (m_state == LEVEL_1) begin
        if (frm) begin
          if (hit(int'(bus.xpos_player), int'(bus.ypos_player), 740, 500, 60, 80) && bus.button_pressed)
            m_dwell = (m_dwell < 30) ? m_dwell + 1 : 30;
          else
            m_dwell = 0;
          if (m_dwell == 30) begin m_pend = 1; m_tgt = FINISH; end
        end
      end else begin
        if (frm) m_fin++;
        if ((frm && m_fin == 299) || clk_ev) begin m_pend = 1; m_tgt = START; end
      end
    end
    m_vb_q = bus.vblnk;
    m_ml_q = bus.mouse_left;
  endtask

  task automatic cyc();
    @(posedge clk_40);
    model_step();
    #1;
    if (model_chk) begin
      check("model_state",  int'(bus.game_state),   int'(m_state));
      check("model_change", int'(bus.state_change), int'(m_change));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.vblnk = 1'b0;
    bus.mouse_left = 1'b0;
    repeat (2) @(negedge clk_40);
    rst = 1'b0;
    model_reset();
  endtask

  // Three low cycles then the rising cycle; returns just after the frame-edge clock.
  task automatic frame();
    bus.vblnk = 1'b0;
    repeat (3) cyc();
    bus.vblnk = 1'b1;
    cyc();
  endtask

  task automatic click();
    bus.mouse_left = 1'b1; cyc();
    bus.mouse_left = 1'b0; cyc();
  endtask

  task automatic set_mouse(input int x, input int y);
    bus.xpos_mouse = 12'(x); bus.ypos_mouse = 12'(y);
  endtask

  task automatic set_player(input int x, input int y, input bit btn);
    bus.xpos_player = 12'(x); bus.ypos_player = 12'(y); bus.button_pressed = btn;
  endtask

  task automatic goto_level1();
    do_reset();
    set_mouse(360, 290);
    click();
    frame();
  endtask

  task automatic goto_finish();
    goto_level1();
    set_player(750, 510, 1'b1);
    repeat (31) frame();
  endtask

  typedef struct {
    bit     zone;
    int     x;
    int     y;
    bit     btn;
    g_state exp;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int n0;
    vecs[0]  = '{1'b0,  360, 290, 1'b0, LEVEL_1};
    vecs[1]  = '{1'b0,  349, 290, 1'b0, START};
    vecs[2]  = '{1'b0,  450, 290, 1'b0, START};
    vecs[3]  = '{1'b0,  350, 280, 1'b0, LEVEL_1};
    vecs[4]  = '{1'b0,  449, 319, 1'b0, LEVEL_1};
    vecs[5]  = '{1'b0,  449, 320, 1'b0, START};
    vecs[6]  = '{1'b0,  350, 279, 1'b0, START};
    vecs[7]  = '{1'b0, 4095, 290, 1'b0, START};
    vecs[8]  = '{1'b1,  750, 510, 1'b1, FINISH};
    vecs[9]  = '{1'b1,  740, 500, 1'b1, FINISH};
    vecs[10] = '{1'b1,  799, 579, 1'b1, FINISH};
    vecs[11] = '{1'b1,  800, 510, 1'b1, LEVEL_1};
    vecs[12] = '{1'b1,  739, 510, 1'b1, LEVEL_1};
    vecs[13] = '{1'b1,  750, 580, 1'b1, LEVEL_1};
    vecs[14] = '{1'b1,  750, 499, 1'b1, LEVEL_1};
    vecs[15] = '{1'b1,  750, 510, 1'b0, LEVEL_1};

    rst = 1'b1;
    bus.vblnk = 1'b0; bus.mouse_left = 1'b0;
    set_mouse(0, 0); set_player(0, 0, 1'b0);
    repeat (2) @(negedge clk_40);
    rst = 1'b0;
    model_reset();

    // 1: reset asserted mid-frame, then idle frames
    bus.vblnk = 1'b1;
    repeat (3) cyc();
    rst = 1'b1;
    #1;
    check("reset_state",  int'(bus.game_state),   int'(START));
    check("reset_change", int'(bus.state_change), 0);
    repeat (2) @(negedge clk_40);
    rst = 1'b0;
    model_reset();
    n0 = n_changes;
    repeat (3) frame();
    check("idle_state",   int'(bus.game_state), int'(START));
    check("idle_changes", n_changes - n0, 0);

    // Hit-box table
    for (int i = 0; i < 16; i++) begin
      if (!vecs[i].zone) begin
        do_reset();
        set_mouse(vecs[i].x, vecs[i].y);
        click();
        frame();
        frame();
      end else begin
        goto_level1();
        set_player(vecs[i].x, vecs[i].y, vecs[i].btn);
        repeat (31) frame();
      end
      check($sformatf("vec%0d", i), int'(bus.game_state), int'(vecs[i].exp));
    end

    // 2: start click commits one cycle after the next vblnk rise, single pulse
    do_reset();
    set_mouse(360, 290);
    n0 = n_changes;
    click();
    check("click_wait_state", int'(bus.game_state), int'(START));
    frame();
    check("click_commit_state",  int'(bus.game_state),   int'(LEVEL_1));
    check("click_commit_change", int'(bus.state_change), 1);
    cyc();
    check("click_pulse_end", int'(bus.state_change), 0);
    frame();
    check("click_pulse_count", n_changes - n0, 1);

    // 3: dwell of 30 frames, FINISH on the 31st
    goto_level1();
    set_player(750, 510, 1'b1);
    repeat (30) frame();
    check("dwell30_state", int'(bus.game_state), int'(LEVEL_1));
    frame();
    check("dwell31_state",  int'(bus.game_state),   int'(FINISH));
    check("dwell31_change", int'(bus.state_change), 1);

    // 3b: button dropped on frame 20 restarts the dwell
    goto_level1();
    for (int k = 1; k <= 51; k++) begin
      set_player(750, 510, (k != 20));
      frame();
      if (k == 31) check("drop_f31_state", int'(bus.game_state), int'(LEVEL_1));
      if (k == 50) check("drop_f50_state", int'(bus.game_state), int'(LEVEL_1));
      if (k == 51) check("drop_f51_state", int'(bus.game_state), int'(FINISH));
    end

    // 4: FINISH timeout at frame edge 300
    goto_finish();
    check("finish_entry", int'(bus.game_state), int'(FINISH));
    set_player(0, 0, 1'b0);
    for (int k = 1; k <= 300; k++) begin
      frame();
      if (k == 299) check("timeout_f299", int'(bus.game_state), int'(FINISH));
      if (k == 300) begin
        check("timeout_f300",        int'(bus.game_state),   int'(START));
        check("timeout_f300_change", int'(bus.state_change), 1);
      end
    end

    // 4b: click anywhere after frame 10 returns at frame 11
    goto_finish();
    set_player(0, 0, 1'b0);
    repeat (10) frame();
    set_mouse(5, 5);
    click();
    check("fin_click_wait", int'(bus.game_state), int'(FINISH));
    frame();
    check("fin_click_f11", int'(bus.game_state), int'(START));

    // 5: click on the same cycle as the vblnk rise
    do_reset();
    repeat (2) cyc();
    set_mouse(360, 290);
    bus.mouse_left = 1'b1;
    bus.vblnk = 1'b1;
    cyc();
    check("coinc_same_edge",   int'(bus.game_state),   int'(START));
    check("coinc_same_change", int'(bus.state_change), 0);
    bus.mouse_left = 1'b0;
    cyc();
    frame();
    check("coinc_next_edge", int'(bus.game_state), int'(LEVEL_1));

    // 6: reset while a request is pending
    do_reset();
    set_mouse(360, 290);
    click();
    rst = 1'b1;
    #1;
    check("pend_rst_state", int'(bus.game_state), int'(START));
    repeat (2) @(negedge clk_40);
    rst = 1'b0;
    model_reset();
    n0 = n_changes;
    repeat (3) frame();
    check("pend_rst_after",   int'(bus.game_state), int'(START));
    check("pend_rst_changes", n_changes - n0, 0);

    // Randomized run against the reference model
    do_reset();
    model_chk = 1'b1;
    set_player(750, 510, 1'b1);
    for (int c = 0; c < 4000; c++) begin
      bus.vblnk = ((c % 7) >= 5);
      if ($urandom_range(0, 9) == 0) bus.vblnk = ~bus.vblnk;
      bus.mouse_left = ($urandom_range(0, 23) == 0);
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0)
          set_mouse(int'($urandom_range(345, 455)), int'($urandom_range(275, 325)));
        else
          set_mouse(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
      end
      if ($urandom_range(0, 299) == 0) begin
        if ($urandom_range(0, 3) != 0)
          set_player(int'($urandom_range(735, 805)), int'($urandom_range(495, 585)),
                     ($urandom_range(0, 7) != 0));
        else
          set_player(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b1);
      end
      if ($urandom_range(0, 999) == 0) do_reset();
      cyc();
    end
    model_chk = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
